pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline. It observes the decode-stage instruction and the execute-stage load and generates hold, bubble and flush controls for the PC, the F/D register and the D/E register. It handles load-use hazards, jump/branch wrong-path flushing, memory wait freezes and the halt-drain sequence.

Parameters:
FLUSH_CYC, 3, total cycles flush_fd is asserted per jump/branch, counting the detection cycle; legal range 1..7
LOAD_LAT, 1, bubbles inserted per load-use hazard; legal range 1..7
DRAIN_CYC, 4, cycles allowed for in-flight instructions to retire after halt, before halted asserts; legal range 1..7
HALT_OP, 6'h3F, decode opcode that requests halt

Ports:
clk  in  1  clock, rising edge
rstd  in  1  asynchronous active-low reset
op_d  in  6  opcode of the instruction in decode
jon_d  in  2  decode jump info: 00 none, 01 conditional branch, 1x unconditional jump
rs_d  in  5  decode source register 1
rt_d  in  5  decode source register 2
ld_e  in  1  execute-stage instruction is a load
rd_e  in  5  execute-stage destination register
mem_wait  in  1  data memory not ready; freeze request
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
bubble_e  out  1  load NOP into D/E register
flush_fd  out  1  replace the F/D instruction with NOP
halted  out  1  pipeline is stopped, sticky
state  out  3  current FSM state, for debug

Behaviour:
- Reset: rstd=0 asynchronously sets state=RUN and counters=0. It also forces stall_f, stall_d, bubble_e, flush_fd and halted to 0. Asserting reset mid-sequence abandons the sequence with no residue.
- States: RUN=0, LDSTALL=1, FLUSH=2, DRAIN=3, HALT=4. One 3-bit down-counter cnt is shared by all states.
- Outputs are combinational from the state, cnt and the current inputs. Hazard response has 0-cycle latency.
- hazard = ld_e & (rd_e!=0) & ((rd_e==rs_d) | (rd_e==rt_d)).
- mem_wait=1 in any state except HALT:
  - stall_f=stall_d=1, bubble_e=0, flush_fd=0.
  - state and cnt hold; no new events are evaluated.
  - mem_wait has priority over every rule below.
- RUN, priority high to low:
  1. op_d==HALT_OP: stall_f=stall_d=1, bubble_e=1. Next state DRAIN with cnt=DRAIN_CYC-1. If DRAIN_CYC==1, next state is HALT.
  2. hazard: stall_f=stall_d=1, bubble_e=1. If LOAD_LAT>1, next state LDSTALL with cnt=LOAD_LAT-1; otherwise stay in RUN.
  3. jon_d!=00: flush_fd=1. If FLUSH_CYC>1, next state FLUSH with cnt=FLUSH_CYC-1.
  4. Otherwise all controls are 0.
- Simultaneous events:
  - Halt beats jump and hazard.
  - Hazard beats jump: the jump is re-evaluated once the stall ends, because the jump may read the loaded register.
- LDSTALL: stall_f=stall_d=bubble_e=1. cnt decrements each cycle. When cnt==1 at a clock edge, the next state is RUN. op_d and jon_d are ignored.
- FLUSH: flush_fd=1, all other controls 0. cnt decrements each cycle; cnt==1 leads to RUN. op_d, jon_d and hazard are ignored, because the decode slot is wrong-path or NOP.
- DRAIN: stall_f=stall_d=1, bubble_e=1. cnt decrements each cycle; cnt==1 leads to HALT. All inputs except mem_wait are ignored.
- HALT: halted=1, stall_f=stall_d=1, bubble_e=1, flush_fd=0. Terminal; only reset exits this state. mem_wait is ignored.
- Counter arithmetic is 3-bit unsigned and never underflows, because the legal parameter ranges guarantee cnt>=1 on entry.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, a 16-bit output port stall_cnt is added.
  - It increments on each clock where stall_f==1 and state!=HALT.
  - It saturates at 16'hFFFF.
  - Reset value is 0.
- When undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- Load-use, defaults: ld_e=1, rd_e=5, rs_d=5 in RUN -> stall_f=stall_d=bubble_e=1 for exactly 1 cycle, then all 0. Repeat with rd_e=0 -> no stall.
- Jump, FLUSH_CYC=3: jon_d=2'b10 for 1 cycle -> flush_fd=1 for 3 consecutive cycles; state sequence 0,2,2,0; a second jon_d during FLUSH adds no extra cycles.
- Halt drain, DRAIN_CYC=4: op_d=6'h3F -> stall_f=1 from that cycle on, bubble_e=1 for 4 cycles, halted=1 on the 5th cycle and held for 20 cycles regardless of inputs.
- Priority: op_d=6'h3F with jon_d=2'b01 and hazard=1 together -> DRAIN entered and flush_fd=0. Hazard with jon_d=2'b10 -> stall first, flush_fd=1 only in the cycle after the stall.
- Freeze: mem_wait=1 for 3 cycles mid-FLUSH (cnt=1) -> flush_fd=0 and stall_f=stall_d=1 during the freeze; after release, one more flush cycle, then RUN.
- Reset mid-DRAIN: drop rstd asynchronously between edges -> all outputs 0 immediately and state=0. With PIPE_HAZARD_PERF_EN, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage in-order pipeline: load-use stalls, wrong-path flushes,
// memory-wait freezes and halt drain. Define PIPE_HAZARD_PERF_EN to add the stall_cnt perf counter.
module pipe_hazard_ctrl #(
    parameter int          FLUSH_CYC = 3,
    parameter int          LOAD_LAT  = 1,
    parameter int          DRAIN_CYC = 4,
    parameter logic [5:0]  HALT_OP   = 6'h3F
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [5:0]  op_d,
    input  logic [1:0]  jon_d,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        ld_e,
    input  logic [4:0]  rd_e,
    input  logic        mem_wait,
    output logic        stall_f,
    output logic        stall_d,
    output logic        bubble_e,
    output logic        flush_fd,
    output logic        halted,
    output logic [2:0]  state
`ifdef PIPE_HAZARD_PERF_EN
   ,output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        LDSTALL = 3'd1,
        FLUSH   = 3'd2,
        DRAIN   = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);
    localparam logic [2:0] LOAD_INIT  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hazard;
    logic       stall_f_c, stall_d_c, bubble_e_c, flush_fd_c, halted_c;

    assign hazard = ld_e && (rd_e != 5'd0) && ((rd_e == rs_d) || (rd_e == rt_d));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        bubble_e_c = 1'b0;
        flush_fd_c = 1'b0;
        halted_c   = 1'b0;

        if (state_q == HALT) begin
            halted_c   = 1'b1;
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            bubble_e_c = 1'b1;
        end else if (mem_wait) begin
            // Freeze: hold everything, evaluate nothing new.
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (op_d == HALT_OP) begin
                        stall_f_c  = 1'b1;
                        stall_d_c  = 1'b1;
                        bubble_e_c = 1'b1;
                        if (DRAIN_CYC == 1) begin
                            state_d = HALT;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = DRAIN_INIT;
                        end
                    end else if (hazard) begin
                        // A jump waiting on the loaded register is re-seen once the stall ends.
                        stall_f_c  = 1'b1;
                        stall_d_c  = 1'b1;
                        bubble_e_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LDSTALL;
                            cnt_d   = LOAD_INIT;
                        end
                    end else if (jon_d != 2'b00) begin
                        flush_fd_c = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end
                    end
                end
                LDSTALL: begin
                    stall_f_c  = 1'b1;
                    stall_d_c  = 1'b1;
                    bubble_e_c = 1'b1;
                    cnt_d      = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RUN;
                end
                FLUSH: begin
                    flush_fd_c = 1'b1;
                    cnt_d      = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RUN;
                end
                DRAIN: begin
                    stall_f_c  = 1'b1;
                    stall_d_c  = 1'b1;
                    bubble_e_c = 1'b1;
                    cnt_d      = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset must silence the controls even though they are combinational from live inputs.
    assign stall_f  = rstd & stall_f_c;
    assign stall_d  = rstd & stall_d_c;
    assign bubble_e = rstd & bubble_e_c;
    assign flush_fd = rstd & flush_fd_c;
    assign halted   = rstd & halted_c;
    assign state    = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (state_q != HALT) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) stall_cnt_q <= 16'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle-level reference model predicts each cycle's
// controls, a monitor on the falling edge compares the DUT against the queued prediction.
module tb_pipe_hazard_ctrl;

    localparam int         FC = 3;
    localparam int         LL = 1;
    localparam int         DC = 4;
    localparam logic [5:0] HOP = 6'h3F;

    logic        clk = 1'b0;
    logic        rstd;
    logic [5:0]  op_d;
    logic [1:0]  jon_d;
    logic [4:0]  rs_d, rt_d, rd_e;
    logic        ld_e, mem_wait;
    logic        stall_f, stall_d, bubble_e, flush_fd, halted;
    logic [2:0]  state;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt;
`endif

    pipe_hazard_ctrl #(.FLUSH_CYC(FC), .LOAD_LAT(LL), .DRAIN_CYC(DC), .HALT_OP(HOP)) dut (
        .clk(clk), .rstd(rstd), .op_d(op_d), .jon_d(jon_d), .rs_d(rs_d), .rt_d(rt_d),
        .ld_e(ld_e), .rd_e(rd_e), .mem_wait(mem_wait),
        .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .flush_fd(flush_fd),
        .halted(halted), .state(state)
`ifdef PIPE_HAZARD_PERF_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sf, sd, be, fl, h;
        logic [2:0]  st;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining cycles of each pending action.
    int drain_left, stall_left, flush_left, sc_m, halt_age;
    bit m_halted;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        drain_left = 0; stall_left = 0; flush_left = 0; sc_m = 0; m_halted = 0; halt_age = 0;
    endtask

    task automatic model_push();
        exp_t e;
        bit   haz;
        e = '0;
        e.sc = 16'(sc_m);
        e.st = m_halted ? 3'd4 : (drain_left > 0) ? 3'd3 : (stall_left > 0) ? 3'd1 :
               (flush_left > 0) ? 3'd2 : 3'd0;
        haz = ld_e && (rd_e != 0) && (rd_e == rs_d || rd_e == rt_d);
        if (m_halted) begin
            e.h = 1; e.sf = 1; e.sd = 1; e.be = 1;
            halt_age++;
        end else if (mem_wait) begin
            e.sf = 1; e.sd = 1;
        end else if (drain_left > 0) begin
            e.sf = 1; e.sd = 1; e.be = 1;
            drain_left--;
            if (drain_left == 0) m_halted = 1;
        end else if (stall_left > 0) begin
            e.sf = 1; e.sd = 1; e.be = 1;
            stall_left--;
        end else if (flush_left > 0) begin
            e.fl = 1;
            flush_left--;
        end else if (op_d == HOP) begin
            e.sf = 1; e.sd = 1; e.be = 1;
            drain_left = DC - 1;
            if (drain_left == 0) m_halted = 1;
        end else if (haz) begin
            e.sf = 1; e.sd = 1; e.be = 1;
            stall_left = LL - 1;
        end else if (jon_d != 2'b00) begin
            e.fl = 1;
            flush_left = FC - 1;
        end
        if (e.sf && e.st != 3'd4 && sc_m < 16'hFFFF) sc_m++;
        q.push_back(e);
    endtask

    task automatic cyc(input logic [5:0] op, input logic [1:0] jon, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ld, input logic [4:0] rd, input logic mw);
        op_d = op; jon_d = jon; rs_d = rs; rt_d = rt; ld_e = ld; rd_e = rd; mem_wait = mw;
        model_push();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(6'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Asynchronous reset dropped between edges with busy-looking inputs; outputs must be 0 at once.
    task automatic rst_cyc();
        exp_t e;
        op_d = HOP; jon_d = 2'b10; rs_d = 5'd3; rt_d = 5'd3; ld_e = 1'b1; rd_e = 5'd3; mem_wait = 1'b0;
        rstd = 1'b0;
        model_reset();
        e = '0;
        q.push_back(e);
        @(posedge clk); #2;
        rstd = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall_f", 16'(stall_f), 16'(e.sf));
            chk("stall_d", 16'(stall_d), 16'(e.sd));
            chk("bubble_e", 16'(bubble_e), 16'(e.be));
            chk("flush_fd", 16'(flush_fd), 16'(e.fl));
            chk("halted", 16'(halted), 16'(e.h));
            chk("state", 16'(state), 16'(e.st));
`ifdef PIPE_HAZARD_PERF_EN
            chk("stall_cnt", stall_cnt, e.sc);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rstd = 1'b1;
        op_d = '0; jon_d = '0; rs_d = '0; rt_d = '0; ld_e = 1'b0; rd_e = '0; mem_wait = 1'b0;
        model_reset();
        #1 rstd = 1'b0;
        @(posedge clk); #2;
        rst_cyc();
        rst_cyc();

        // Load-use, then the same with rd_e = 0.
        cyc(6'd0, 2'b00, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
        idle(2);
        cyc(6'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        idle(1);

        // Jump with a second jump during the flush window.
        cyc(6'd0, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(6'd0, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(3);

        // Halt + branch + hazard together, then halted held while inputs toggle.
        cyc(HOP, 2'b01, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
        for (int i = 0; i < 25; i++)
            cyc(6'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                1'($urandom));
        rst_cyc();

        // Hazard with a jump: stall first, flush afterwards.
        cyc(6'd0, 2'b10, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0);
        cyc(6'd0, 2'b10, 5'd0, 5'd7, 1'b0, 5'd7, 1'b0);
        idle(3);

        // Freeze for 3 cycles at the last flush cycle.
        cyc(6'd0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(6'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        idle(2);

        // Reset mid-drain.
        cyc(HOP, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle(2);
        rst_cyc();
        idle(1);

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 200 == 0) || halt_age > 20) begin
                rst_cyc();
            end else begin
                cyc(($urandom % 60 == 0) ? HOP : 6'($urandom_range(0, 62)),
                    ($urandom % 4 == 0) ? 2'($urandom) : 2'b00,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom % 3 == 0), 5'($urandom_range(0, 3)),
                    1'($urandom % 6 == 0));
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
